// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencing controller and its counter.
// Holds the controller state encodings, default bus width and periods width.
package counter_pkg;

   localparam int unsigned SIZE_DEFAULT = 5;
   localparam int unsigned PERIODS_W    = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      RESTART = 2'b10
   } ctrl_state_t;

endpackage

// File: rtl/counter.sv
// Free-running up counter sequenced by counter_ctrl.
// A high reset at a rising edge returns the count to zero; otherwise it increments and wraps.
module counter
   import counter_pkg::*;
#(
   parameter int unsigned Size = SIZE_DEFAULT
) (
   input  logic            clock,
   input  logic            reset,
   output logic [Size-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= count + Size'(1);
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// Run controller for an external counter: accepts limit/mode commands, pulses done on
// each terminal count and tracks completed periods. Every output comes from registered state.
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int unsigned Size = SIZE_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [Size-1:0]      cmd_limit,
   input  logic                 cmd_periodic,
   input  logic                 cmd_abort,
   input  logic [Size-1:0]      count_in,
   output logic                 counter_reset,
   output logic                 busy,
   output logic                 done,
   output logic [PERIODS_W-1:0] periods
);

   // Command handshake: a command transfers on a rising edge where cmd_valid and
   // cmd_ready are both 1; the requester holds cmd_valid/cmd_limit until then.

   ctrl_state_t          state_q;
   ctrl_state_t          state_d;
   logic [Size-1:0]      limit_q;
   logic                 periodic_q;
   logic [PERIODS_W-1:0] periods_q;
   logic                 done_q;
   logic                 accept;
   logic                 match;

   assign accept = (state_q == IDLE) && cmd_valid;
   // Abort wins over a terminal match sampled at the same edge.
   assign match  = (state_q == RUN) && !cmd_abort && (count_in == limit_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) state_d = RUN;
         end
         RUN: begin
            if (cmd_abort)  state_d = IDLE;
            else if (match) state_d = periodic_q ? RESTART : IDLE;
         end
         RESTART: begin
            state_d = cmd_abort ? IDLE : RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         limit_q    <= '0;
         periodic_q <= 1'b0;
         periods_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= match;
         if (accept) begin
            limit_q    <= cmd_limit;
            periodic_q <= cmd_periodic;
            periods_q  <= '0;
         end else if (match && (periods_q != '1)) begin
            periods_q <= periods_q + PERIODS_W'(1);
         end
      end
   end

   assign cmd_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   // The counter is held at zero everywhere except RUN, so each run starts counting from 0.
   assign counter_reset = (state_q != RUN);
   assign done          = done_q;
   assign periods       = periods_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl paired with counter (Size=5): vector table, hand-written
// corner sequences, and randomized runs against a done-schedule reference model.
module tb_counter_ctrl;
   import counter_pkg::*;

   localparam int SZ = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [SZ-1:0] cmd_limit;
   logic          cmd_periodic;
   logic          cmd_abort;
   logic [SZ-1:0] count;
   logic          counter_reset;
   logic          busy;
   logic          done;
   logic [7:0]    periods;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   counter_ctrl #(.Size(SZ)) u_ctrl (
      .clock        (clock),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_limit    (cmd_limit),
      .cmd_periodic (cmd_periodic),
      .cmd_abort    (cmd_abort),
      .count_in     (count),
      .counter_reset(counter_reset),
      .busy         (busy),
      .done         (done),
      .periods      (periods)
   );

   counter #(.Size(SZ)) u_counter (
      .clock(clock),
      .reset(counter_reset),
      .count(count)
   );

   typedef struct {
      int limit;
      bit periodic;
      int abort_at;
      int exp_first;
      int exp_ndone;
      int exp_periods;
   } vec_t;

   vec_t tv[6];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge with the controller idle; returns at the negedge of cycle 0
   // (the cycle right after the accept edge).
   task automatic issue(input int limit, input bit per);
      cmd_valid    = 1'b1;
      cmd_limit    = SZ'(limit);
      cmd_periodic = per;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic settle();
      cmd_abort = 1'b1;
      @(negedge clock);
      cmd_abort = 1'b0;
      @(negedge clock);
   endtask

   // Expected outputs in cycle k after the accept edge. Terminal matches land on
   // edges L+1, L+1+(L+2), ...; an abort driven in cycle ab takes effect at edge ab+1.
   task automatic model(input int L, input bit per, input int ab, input int k,
                        output bit e_done, output bit e_busy, output bit e_rst,
                        output int e_per, output int e_cnt);
      int abort_edge;
      int end_c;
      int run_start;
      int m;
      abort_edge = (ab >= 0) ? ab + 1 : 1000000;
      end_c      = abort_edge;
      if (!per && (L + 1 < end_c)) end_c = L + 1;
      e_busy    = (k < end_c);
      e_done    = 1'b0;
      e_per     = 0;
      e_rst     = !e_busy;
      run_start = 0;
      for (int j = 0; j < 1000; j++) begin
         m = L + 1 + j * (L + 2);
         if (m > k || m >= abort_edge || (!per && j > 0)) break;
         if (e_per < 255) e_per++;
         if (m == k) e_done = 1'b1;
         if (per) begin
            if (m == k) e_rst = 1'b1;
            run_start = m + 1;
         end
      end
      e_cnt = (e_busy && !e_rst) ? k - run_start : -1;
   endtask

   initial begin
      int first;
      int nd;
      bit cnt_ok;
      bit e_done, e_busy, e_rst;
      int e_per, e_cnt, L, ab;
      bit per;

      tv[0] = '{limit: 3,  periodic: 0, abort_at: -1, exp_first: 4,  exp_ndone: 1, exp_periods: 1};
      tv[1] = '{limit: 0,  periodic: 0, abort_at: -1, exp_first: 1,  exp_ndone: 1, exp_periods: 1};
      tv[2] = '{limit: 31, periodic: 0, abort_at: -1, exp_first: 32, exp_ndone: 1, exp_periods: 1};
      tv[3] = '{limit: 5,  periodic: 0, abort_at: 2,  exp_first: -1, exp_ndone: 0, exp_periods: 0};
      tv[4] = '{limit: 4,  periodic: 0, abort_at: 4,  exp_first: -1, exp_ndone: 0, exp_periods: 0};
      tv[5] = '{limit: 2,  periodic: 1, abort_at: 20, exp_first: 3,  exp_ndone: 5, exp_periods: 5};

      reset        = 1'b1;
      cmd_valid    = 1'b0;
      cmd_limit    = '0;
      cmd_periodic = 1'b0;
      cmd_abort    = 1'b0;
      #1;
      check("rst cmd_ready", int'(cmd_ready), 1);
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      check("rst periods", int'(periods), 0);
      check("rst counter_reset", int'(counter_reset), 1);
      @(negedge clock);
      reset = 1'b0;

      // First command right after reset release is accepted on the first edge.
      issue(3, 0);
      check("first accept busy", int'(busy), 1);
      for (int k = 0; k < 6; k++) @(negedge clock);
      settle();

      // Vector table
      for (int i = 0; i < 6; i++) begin
         issue(tv[i].limit, tv[i].periodic);
         first  = -1;
         nd     = 0;
         cnt_ok = 1'b1;
         for (int k = 0; k < 40; k++) begin
            if (done) begin
               nd++;
               if (first < 0) first = k;
            end
            if (first < 0 && busy && !counter_reset && (int'(count) != k)) cnt_ok = 1'b0;
            if (done && tv[i].periodic == 1'b0) check("vec ready with done", int'(cmd_ready), 1);
            cmd_abort = (k == tv[i].abort_at);
            @(negedge clock);
         end
         cmd_abort = 1'b0;
         check($sformatf("vec%0d first done", i), first, tv[i].exp_first);
         check($sformatf("vec%0d done count", i), nd, tv[i].exp_ndone);
         check($sformatf("vec%0d periods", i), int'(periods), tv[i].exp_periods);
         check($sformatf("vec%0d count no wrap", i), int'(cnt_ok), 1);
         settle();
      end

      // Abort together with a command in IDLE: command still accepted.
      cmd_abort = 1'b1;
      issue(7, 0);
      cmd_abort = 1'b0;
      check("abort+valid idle busy", int'(busy), 1);
      settle();

      // Reset mid-run at count 4 of limit 10.
      issue(10, 0);
      for (int k = 0; k < 4; k++) @(negedge clock);
      check("mid-run count", int'(count), 4);
      #2 reset = 1'b1;
      #1;
      check("async rst cmd_ready", int'(cmd_ready), 1);
      check("async rst busy", int'(busy), 0);
      check("async rst done", int'(done), 0);
      check("async rst periods", int'(periods), 0);
      check("async rst counter_reset", int'(counter_reset), 1);
      @(negedge clock);
      check("rst held count", int'(count), 0);
      check("rst held done", int'(done), 0);
      reset = 1'b0;
      issue(1, 0);
      first = -1;
      for (int k = 0; k < 6; k++) begin
         if (done && first < 0) first = k;
         @(negedge clock);
      end
      check("post-reset first done", first, 2);

      // Backpressure: second command held while the first one-shot runs.
      issue(3, 0);
      cmd_valid = 1'b1;
      cmd_limit = SZ'(6);
      for (int k = 0; k < 4; k++) begin
         check("bp cmd_ready low", int'(cmd_ready), 0);
         check("bp no early done", int'(done), 0);
         @(negedge clock);
      end
      check("bp done", int'(done), 1);
      check("bp ready with done", int'(cmd_ready), 1);
      check("bp periods", int'(periods), 1);
      @(negedge clock);
      cmd_valid = 1'b0;
      check("bp second accepted", int'(busy), 1);
      check("bp periods cleared", int'(periods), 0);
      first = -1;
      for (int k = 5; k < 16; k++) begin
         if (done && first < 0) first = k;
         @(negedge clock);
      end
      check("bp second done cycle", first, 12);
      settle();

      // Saturation: limit 0 periodic gives one period every 2 cycles.
      issue(0, 1);
      for (int k = 0; k < 530; k++) @(negedge clock);
      check("periods saturate", int'(periods), 255);
      settle();

      // Randomized runs against the reference model.
      for (int it = 0; it < 10; it++) begin
         L   = int'($urandom_range(0, 31));
         per = 1'($urandom_range(0, 1));
         ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1;
         issue(L, per);
         for (int k = 0; k <= 70; k++) begin
            model(L, per, ab, k, e_done, e_busy, e_rst, e_per, e_cnt);
            check("rnd done", int'(done), int'(e_done));
            check("rnd busy", int'(busy), int'(e_busy));
            check("rnd cmd_ready", int'(cmd_ready), int'(!e_busy));
            check("rnd counter_reset", int'(counter_reset), int'(e_rst));
            check("rnd periods", int'(periods), e_per);
            if (e_cnt >= 0) check("rnd count", int'(count), e_cnt);
            cmd_abort = (k == ab);
            @(negedge clock);
         end
         cmd_abort = 1'b0;
         settle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: Size, default 5, width of limit and count buses; SHALL match the width of the counter instance being sequenced.
REQ-002 Ports SHALL be:
- clock  input  1  single design clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller accepts a command this cycle.
- cmd_limit  input  Size  terminal count value.
- cmd_periodic  input  1  1 = auto-restart after terminal count; 0 = one-shot.
- cmd_abort  input  1  stop the current run.
- count_in  input  Size  count bus from the counter instance.
- counter_reset  output  1  drives the counter's reset; 1 holds the count at 0.
- busy  output  1  a run is in progress.
- done  output  1  one-cycle pulse per terminal count reached.
- periods  output  8  completed periods since the last accepted command.

Function
REQ-003 States SHALL be IDLE, RUN and RESTART, with 2-bit encoding 00, 01 and 10.
REQ-004 IDLE: cmd_ready=1, counter_reset=1, busy=0; a command is accepted when cmd_valid=1 and cmd_ready=1.
REQ-005 On accept:
- latch cmd_limit into limit_q and cmd_periodic into periodic_q;
- clear periods to 0;
- go to RUN at the next edge.
REQ-006 RUN: counter_reset=0, busy=1, cmd_ready=0; the counter increments once per clock starting from 0.
REQ-007 Terminal match SHALL be count_in == limit_q, sampled at a rising edge in RUN. At that edge:
- done=1 for exactly the following cycle;
- periods increments by 1, saturating at 255;
- next state is RESTART if periodic_q=1, otherwise IDLE.
REQ-008 RESTART lasts exactly one cycle: counter_reset=1, busy=1, cmd_ready=0; the next state is RUN.
REQ-009 Timing:
- latency from the accept edge to the first done pulse SHALL be limit_q+1 cycles;
- in periodic mode the done pulses SHALL be spaced limit_q+2 cycles apart.
REQ-010 limit_q=0 SHALL produce done one cycle after RUN entry.
REQ-011 limit_q = 2^Size-1 SHALL match before the counter wraps; the controller never relies on counter wrap-around.
REQ-012 cmd_abort=1 in RUN or RESTART SHALL force IDLE at the next edge with no done pulse and no periods increment.
REQ-013 Abort SHALL take priority over a terminal match in the same cycle.
REQ-014 cmd_abort in IDLE SHALL be ignored.
REQ-015 cmd_abort together with cmd_valid in IDLE: the command SHALL be accepted.
REQ-016 While busy, cmd_valid SHALL be ignored (cmd_ready=0); the requester holds cmd_valid and cmd_limit until accepted.
REQ-017 A one-shot completion SHALL raise cmd_ready one cycle after the match edge, concurrent with the done pulse.
REQ-018 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Reset
REQ-019 Asserting reset SHALL immediately, without waiting for a clock edge, force:
- state IDLE;
- counter_reset=1, cmd_ready=1, busy=0, done=0, periods=0, limit_q=0, periodic_q=0.
REQ-020 Reset mid-run SHALL discard the run silently: no done pulse, and periods is cleared.
REQ-021 After reset deasserts, the first command SHALL be accepted on the first rising edge with cmd_valid=1.

Structure
REQ-022 A shared package (counter_pkg) SHALL hold the state encodings (IDLE/RUN/RESTART), the default Size=5 and the periods width (8).
REQ-023 counter_ctrl SHALL contain no sub-modules.
REQ-024 The existing counter SHALL be instantiated beside counter_ctrl at the level above, with counter_reset driving its reset and its count driving count_in.

Verification
REQ-025 The bench SHALL pair counter_ctrl with counter (Size=5), use a 10-time-unit clock, and cover:
- One-shot: limit=3, periodic=0 -> count 0,1,2,3; done high 4 cycles after accept; cmd_ready back to 1 with done; periods=1.
- Periodic: limit=2, periodic=1, run 20 cycles -> done every 4 cycles; periods counts 1,2,3,...; counter_reset high exactly one cycle per period.
- Boundaries: limit=0 -> done 1 cycle after accept; limit=31 -> done 32 cycles after accept, count never wraps to 0 before the match.
- Abort: abort at count=2 of limit=5 -> IDLE next edge, no done, periods=0.
- Abort coinciding with count==limit -> no done.
- Reset: reset asserted mid-run at count=4 of limit=10 -> outputs at reset values without a clock edge; a new command with limit=1 after release -> done 2 cycles after accept.
- Backpressure: cmd_valid held during a run -> cmd_ready=0 throughout; the command is accepted on the cycle after the one-shot match edge, with its new limit latched.
